// File: rtl/btn_pkg.sv
// Shared types and default parameter values for the push-button debouncer.
package btn_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } btn_state_e;

    localparam int unsigned SyncStagesDef     = 2;
    localparam int unsigned DebounceCyclesDef = 16;
    localparam int unsigned LongCyclesDef     = 64;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw input toward the debouncer, cleaned level and event pulses back.
interface btn_debounce_if;

    logic btn_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic btn_long;

    // Button source / consumer side
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_long
    );

    // Debouncer side
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_long
    );

endinterface

// File: rtl/btn_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, cleared by reset.
module btn_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstbtn_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_stages;

    // Shift the raw input through the flop chain; only the last stage is used downstream
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, 4-state stability FSM, press/release/long-press pulses.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned LONG_CYCLES     = LongCyclesDef
) (
    input  logic           clk,
    input  logic           rstbtn_n,
    btn_debounce_if.slave  bus
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

    localparam logic [DbW-1:0]   DbOne    = DbW'(1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

    logic             w_sync;
    btn_state_e       r_state;
    logic [DbW-1:0]   r_db_cnt;
    logic [HoldW-1:0] r_hold_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_long;

    logic             w_hold_sat;
    logic [HoldW-1:0] w_hold_next;
    logic             w_long_hit;

    btn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstbtn_n (rstbtn_n),
        .i_async  (bus.btn_raw),
        .o_sync   (w_sync)
    );

    // Hold counter saturates so the long-press pulse fires only once per press
    assign w_hold_sat  = (r_hold_cnt == HoldMax);
    assign w_hold_next = w_hold_sat ? r_hold_cnt : r_hold_cnt + HoldOne;
    assign w_long_hit  = !w_hold_sat && (r_hold_cnt == HoldMax - HoldOne);

    // Debounce FSM with counters and registered level/pulse outputs
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_state    <= StLow;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_long <= 1'b0;
            unique case (r_state)
                StLow: begin
                    if (w_sync) begin
                        r_state  <= StWaitHigh;
                        r_db_cnt <= DbOne;
                    end
                end
                StWaitHigh: begin
                    if (!w_sync) begin
                        r_state  <= StLow;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DbLast) begin
                        r_state    <= StHigh;
                        r_db_cnt   <= '0;
                        r_hold_cnt <= '0;
                        r_level    <= 1'b1;
                        r_rise     <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DbOne;
                    end
                end
                StHigh: begin
                    if (!w_sync) begin
                        r_state  <= StWaitLow;
                        r_db_cnt <= DbOne;
                    end
                    r_hold_cnt <= w_hold_next;
                    r_long     <= w_long_hit;
                end
                StWaitLow: begin
                    if (w_sync) begin
                        // Release bounce: back to pressed, hold count keeps running
                        r_state    <= StHigh;
                        r_db_cnt   <= '0;
                        r_hold_cnt <= w_hold_next;
                        r_long     <= w_long_hit;
                    end else if (r_db_cnt == DbLast) begin
                        r_state  <= StLow;
                        r_db_cnt <= '0;
                        r_level  <= 1'b0;
                        r_fall   <= 1'b1;
                    end else begin
                        r_db_cnt   <= r_db_cnt + DbOne;
                        r_hold_cnt <= w_hold_next;
                        r_long     <= w_long_hit;
                    end
                end
                default: begin
                    r_state <= StLow;
                end
            endcase
        end
    end

    assign bus.btn_level = r_level;
    assign bus.btn_rise  = r_rise;
    assign bus.btn_fall  = r_fall;
    assign bus.btn_long  = r_long;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with default parameters.
module tb_btn_debounce;

    logic clk;
    logic rstbtn_n;
    int   n_tests;
    int   n_fail;
    int   cyc;

    // Event monitor state
    int n_rise, n_fall, n_long, n_overlap, n_long_bad;
    int t_rise, t_fall, t_long;
    int t0, t1;

    btn_debounce_if bus ();

    btn_debounce u_dut (
        .clk      (clk),
        .rstbtn_n (rstbtn_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record pulses on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (bus.btn_rise === 1'b1) begin
            n_rise = n_rise + 1;
            t_rise = cyc;
        end
        if (bus.btn_fall === 1'b1) begin
            n_fall = n_fall + 1;
            t_fall = cyc;
        end
        if (bus.btn_long === 1'b1) begin
            n_long = n_long + 1;
            t_long = cyc;
            if (bus.btn_level !== 1'b1) n_long_bad = n_long_bad + 1;
        end
        if (bus.btn_rise === 1'b1 && bus.btn_fall === 1'b1) n_overlap = n_overlap + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests = n_tests + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_rise = 0;
        n_fall = 0;
        n_long = 0;
        t_rise = -1;
        t_fall = -1;
        t_long = -1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"}, int'(bus.btn_level), 0);
        check({tag, "_rise"},  int'(bus.btn_rise),  0);
        check({tag, "_fall"},  int'(bus.btn_fall),  0);
        check({tag, "_long"},  int'(bus.btn_long),  0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        n_overlap  = 0;
        n_long_bad = 0;
        clear_counts();
        rstbtn_n    = 1'b0;
        bus.btn_raw = 1'b1;

        // Reset state: outputs low even with the button pressed
        wait_n(4);
        check_outputs_zero("reset");
        bus.btn_raw = 1'b0;
        wait_n(2);
        rstbtn_n = 1'b1;
        wait_n(4);

        // Clean press and release
        clear_counts();
        bus.btn_raw = 1'b1;
        t0 = cyc;
        wait_n(17);
        check("clean_level_before", int'(bus.btn_level), 0);
        wait_n(1);
        check("clean_level_at18", int'(bus.btn_level), 1);
        check("clean_rise_at18", int'(bus.btn_rise), 1);
        wait_n(1);
        check("clean_rise_one_cycle", int'(bus.btn_rise), 0);
        wait_n(21);
        check("clean_rise_count", n_rise, 1);
        check("clean_rise_delay", t_rise - t0, 18);
        check("clean_level_held", int'(bus.btn_level), 1);
        check("clean_no_long", n_long, 0);
        bus.btn_raw = 1'b0;
        t0 = cyc;
        wait_n(30);
        check("clean_fall_count", n_fall, 1);
        check("clean_fall_delay", t_fall - t0, 18);
        check("clean_level_low", int'(bus.btn_level), 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            wait_n(3);
        end
        bus.btn_raw = 1'b1;
        t0 = cyc;
        wait_n(40);
        check("bounce_rise_count", n_rise, 1);
        check("bounce_rise_delay", t_rise - t0, 18);
        check("bounce_no_fall", n_fall, 0);
        bus.btn_raw = 1'b0;
        wait_n(30);

        // Long press then release
        clear_counts();
        bus.btn_raw = 1'b1;
        t0 = cyc;
        wait_n(100);
        check("long_rise_delay", t_rise - t0, 18);
        check("long_count", n_long, 1);
        check("long_delay", t_long - t0, 82);
        bus.btn_raw = 1'b0;
        t0 = cyc;
        wait_n(30);
        check("long_fall_delay", t_fall - t0, 18);
        check("long_count_after", n_long, 1);

        // Release glitch while pressed: no fall, hold count keeps running
        clear_counts();
        bus.btn_raw = 1'b1;
        t0 = cyc;
        wait_n(30);
        bus.btn_raw = 1'b0;
        wait_n(5);
        bus.btn_raw = 1'b1;
        wait_n(10);
        check("glitch_no_fall", n_fall, 0);
        check("glitch_level", int'(bus.btn_level), 1);
        wait_n(55);
        check("glitch_long_count", n_long, 1);
        check("glitch_long_delay", t_long - t0, 82);

        // Reset while pressed: immediate clear, then normal press after release
        @(negedge clk);
        rstbtn_n = 1'b0;
        #1;
        check_outputs_zero("rst_high");
        wait_n(3);
        clear_counts();
        rstbtn_n = 1'b1;
        t1 = cyc;
        wait_n(30);
        check("rst_high_rise_count", n_rise, 1);
        check("rst_high_rise_delay", t_rise - t1, 18);
        bus.btn_raw = 1'b0;
        wait_n(30);

        // Reset mid-debounce at cycle 10 of a press
        clear_counts();
        bus.btn_raw = 1'b1;
        wait_n(10);
        rstbtn_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        wait_n(3);
        check("rst_mid_no_rise", n_rise, 0);
        rstbtn_n = 1'b1;
        t1 = cyc;
        wait_n(30);
        check("rst_mid_rise_count", n_rise, 1);
        check("rst_mid_rise_delay", t_rise - t1, 18);

        check("rise_fall_overlap", n_overlap, 0);
        check("long_without_level", n_long_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
